// File: rtl/ddr_arbiter_pkg.sv
// Shared types and default widths for the DDRAM burst-port arbiter.
package ddr_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WRITE     = 2'd1,
      READ_CMD  = 2'd2,
      READ_DATA = 2'd3
   } state_t;

   localparam int DEF_NUM_REQ = 3;
   localparam int DEF_ADDR_W  = 29;
   localparam int DEF_DATA_W  = 64;
   localparam int DEF_BURST_W = 8;
   localparam int MAX_REQ     = 8;

endpackage

// File: rtl/ddr_arbiter_if.sv
// DDRAM Avalon-style burst port; master is the arbiter, slave is the memory side.
interface ddr_arbiter_if #(
   parameter int ADDR_W  = 29,
   parameter int DATA_W  = 64,
   parameter int BURST_W = 8
);
   logic               ddr_busy;
   logic               ddr_rd;
   logic               ddr_we;
   logic [ADDR_W-1:0]  ddr_addr;
   logic [BURST_W-1:0] ddr_burst;
   logic [DATA_W-1:0]  ddr_din;
   logic [7:0]         ddr_be;
   logic [DATA_W-1:0]  ddr_dout;
   logic               ddr_valid;

   modport master (
      input  ddr_busy, ddr_dout, ddr_valid,
      output ddr_rd, ddr_we, ddr_addr, ddr_burst, ddr_din, ddr_be
   );

   modport slave (
      output ddr_busy, ddr_dout, ddr_valid,
      input  ddr_rd, ddr_we, ddr_addr, ddr_burst, ddr_din, ddr_be
   );
endinterface

// File: rtl/ddr_arbiter_rr_picker.sv
// Combinational round-robin picker: first pending index at or after ptr, wrapping.
module rr_picker #(
   parameter int NUM_REQ = 3,
   parameter int IDX_W   = 2
) (
   input  logic [NUM_REQ-1:0] pending,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] onehot,
   output logic [IDX_W-1:0]   idx,
   output logic               none
);
   int   cand;
   logic found;

   always_comb begin
      onehot = '0;
      idx    = '0;
      found  = 1'b0;
      cand   = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = (int'(ptr) + k) % NUM_REQ;
         if (!found && pending[cand]) begin
            found        = 1'b1;
            onehot[cand] = 1'b1;
            idx          = IDX_W'(cand);
         end
      end
      none = ~found;
   end
endmodule

// File: rtl/ddr_arbiter.sv
// Burst-granular round-robin arbiter sharing one DDRAM port between NUM_REQ requesters.
module ddr_arbiter
   import ddr_arbiter_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ,
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int BURST_W = DEF_BURST_W
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_REQ-1:0]         req_rd,
   input  logic [NUM_REQ-1:0]         req_wr,
   input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
   input  logic [NUM_REQ*BURST_W-1:0] req_burst,
   input  logic [NUM_REQ*DATA_W-1:0]  req_din,
   input  logic [NUM_REQ*8-1:0]       req_be,
   output logic [NUM_REQ-1:0]         req_wait_n,
   output logic [NUM_REQ-1:0]         req_valid,
   output logic [DATA_W-1:0]          req_dout,
   output logic [NUM_REQ-1:0]         grant,
   output logic                       err,
   ddr_arbiter_if.master              ddr
);
   localparam int IDX_W = $clog2(NUM_REQ);

   state_t             state_q, state_d;
   logic [NUM_REQ-1:0] grant_q, grant_d;
   logic [IDX_W-1:0]   gidx_q, gidx_d;
   logic [IDX_W-1:0]   ptr_q, ptr_d;
   logic [BURST_W-1:0] len_q, len_d;
   logic [BURST_W-1:0] cnt_q, cnt_d;
   logic               err_q, err_d;

   logic [NUM_REQ-1:0] pick_onehot;
   logic [IDX_W-1:0]   pick_idx;
   logic               pick_none;
   logic [BURST_W-1:0] pick_burst;
   logic [IDX_W-1:0]   next_ptr;
   logic               granted_cmd;

   rr_picker #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_picker (
      .pending (req_rd | req_wr),
      .ptr     (ptr_q),
      .onehot  (pick_onehot),
      .idx     (pick_idx),
      .none    (pick_none)
   );

   assign pick_burst = req_burst[int'(pick_idx)*BURST_W +: BURST_W];
   assign next_ptr   = (gidx_q == IDX_W'(NUM_REQ-1)) ? '0 : gidx_q + IDX_W'(1);

   // The owner drives the DDR command lines directly; only rd/we are gated by state.
   assign granted_cmd   = (state_q == WRITE) || (state_q == READ_CMD);
   assign ddr.ddr_addr  = req_addr[int'(gidx_q)*ADDR_W +: ADDR_W];
   assign ddr.ddr_burst = req_burst[int'(gidx_q)*BURST_W +: BURST_W];
   assign ddr.ddr_din   = req_din[int'(gidx_q)*DATA_W +: DATA_W];
   assign ddr.ddr_be    = req_be[int'(gidx_q)*8 +: 8];
   assign ddr.ddr_we    = (state_q == WRITE) && req_wr[gidx_q];
   assign ddr.ddr_rd    = (state_q == READ_CMD) && req_rd[gidx_q];
   assign req_wait_n    = (granted_cmd && !ddr.ddr_busy) ? grant_q : '0;
   assign req_valid     = ((state_q == READ_DATA) && ddr.ddr_valid) ? grant_q : '0;
   assign req_dout      = ddr.ddr_dout;
   assign grant         = grant_q;
   assign err           = err_q;

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      gidx_d  = gidx_q;
      ptr_d   = ptr_q;
      len_d   = len_q;
      cnt_d   = cnt_q;
      err_d   = err_q | (ddr.ddr_valid && (state_q != READ_DATA));
      case (state_q)
         IDLE: begin
            if (!pick_none) begin
               grant_d = pick_onehot;
               gidx_d  = pick_idx;
               len_d   = (pick_burst == '0) ? BURST_W'(1) : pick_burst;
               cnt_d   = '0;
               state_d = req_wr[pick_idx] ? WRITE : READ_CMD;
            end
         end
         WRITE: begin
            if (ddr.ddr_we && !ddr.ddr_busy) begin
               if (cnt_q == len_q - BURST_W'(1)) begin
                  state_d = IDLE;
                  grant_d = '0;
                  ptr_d   = next_ptr;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + BURST_W'(1);
               end
            end
         end
         READ_CMD: begin
            if (ddr.ddr_rd && !ddr.ddr_busy) begin
               state_d = READ_DATA;
               cnt_d   = len_q;
            end
         end
         READ_DATA: begin
            // cnt holds beats still owed by the memory for this read burst
            if (ddr.ddr_valid) begin
               if (cnt_q == BURST_W'(1)) begin
                  state_d = IDLE;
                  grant_d = '0;
                  ptr_d   = next_ptr;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q - BURST_W'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         grant_q <= '0;
         gidx_q  <= '0;
         ptr_q   <= '0;
         len_q   <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         gidx_q  <= gidx_d;
         ptr_q   <= ptr_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end
endmodule

// File: tb/tb_ddr_arbiter.sv
// Directed bench for ddr_arbiter: write, contention, backpressured read, wrap, reset abort, rd+wr.
module tb_ddr_arbiter;
   localparam int N  = 3;
   localparam int AW = 29;
   localparam int DW = 64;
   localparam int BW = 8;

   logic              clk;
   logic              rst;
   logic [N-1:0]      req_rd;
   logic [N-1:0]      req_wr;
   logic [N*AW-1:0]   req_addr;
   logic [N*BW-1:0]   req_burst;
   logic [N*DW-1:0]   req_din;
   logic [N*8-1:0]    req_be;
   logic [N-1:0]      req_wait_n;
   logic [N-1:0]      req_valid;
   logic [DW-1:0]     req_dout;
   logic [N-1:0]      grant;
   logic              err;

   int passCount;
   int totalCount;

   ddr_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .BURST_W(BW)) ddr ();

   ddr_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .BURST_W(BW)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_rd     (req_rd),
      .req_wr     (req_wr),
      .req_addr   (req_addr),
      .req_burst  (req_burst),
      .req_din    (req_din),
      .req_be     (req_be),
      .req_wait_n (req_wait_n),
      .req_valid  (req_valid),
      .req_dout   (req_dout),
      .grant      (grant),
      .err        (err),
      .ddr        (ddr.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic applyStimulus(input int i, input logic rd, input logic wr,
                                input logic [AW-1:0] addr, input logic [BW-1:0] burst,
                                input logic [DW-1:0] din);
      req_rd[i]              = rd;
      req_wr[i]              = wr;
      req_addr[i*AW +: AW]   = addr;
      req_burst[i*BW +: BW]  = burst;
      req_din[i*DW +: DW]    = din;
      req_be[i*8 +: 8]       = 8'hFF;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      totalCount++;
      assert (observed === expected) passCount++;
      else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   initial begin
      passCount = 0;
      totalCount = 0;
      rst = 1'b1;
      req_rd = '0;
      req_wr = '0;
      req_addr = '0;
      req_burst = '0;
      req_din = '0;
      req_be = '0;
      ddr.ddr_busy = 1'b0;
      ddr.ddr_dout = '0;
      ddr.ddr_valid = 1'b0;

      tick();
      tick();
      checkOutput("reset_grant", 64'(grant), 64'h0);
      checkOutput("reset_rd", 64'(ddr.ddr_rd), 64'h0);
      checkOutput("reset_we", 64'(ddr.ddr_we), 64'h0);
      checkOutput("reset_wait_n", 64'(req_wait_n), 64'h0);
      checkOutput("reset_valid", 64'(req_valid), 64'h0);
      checkOutput("reset_err", 64'(err), 64'h0);

      // single write burst of 4 from requester 0
      @(negedge clk);
      rst = 1'b0;
      applyStimulus(0, 1'b0, 1'b1, 29'h0000100, 8'd4, 64'hA5A5_0000_1111_2222);
      #1;
      checkOutput("wr_arb_grant", 64'(grant), 64'h0);
      checkOutput("wr_arb_we", 64'(ddr.ddr_we), 64'h0);
      for (int b = 0; b < 4; b++) begin
         tick();
         checkOutput("wr_grant", 64'(grant), 64'h1);
         checkOutput("wr_we", 64'(ddr.ddr_we), 64'h1);
         checkOutput("wr_wait_n", 64'(req_wait_n), 64'h1);
         checkOutput("wr_addr", 64'(ddr.ddr_addr), 64'h0000100);
         checkOutput("wr_din", ddr.ddr_din, 64'hA5A5_0000_1111_2222);
      end
      @(negedge clk);
      applyStimulus(0, 1'b0, 1'b0, 29'h0, 8'd0, 64'h0);
      #1;
      checkOutput("wr_done_grant", 64'(grant), 64'h0);
      checkOutput("wr_done_we", 64'(ddr.ddr_we), 64'h0);

      // contention: pointer sits at 1 after the write, so order is 1,2,0,1,2
      @(negedge clk);
      applyStimulus(0, 1'b0, 1'b1, 29'h10, 8'd1, 64'h10);
      applyStimulus(1, 1'b0, 1'b1, 29'h11, 8'd1, 64'h11);
      applyStimulus(2, 1'b0, 1'b1, 29'h12, 8'd1, 64'h12);
      #1;
      checkOutput("cont_idle0", 64'(grant), 64'h0);
      begin
         logic [N-1:0] order [5];
         order[0] = 3'b010;
         order[1] = 3'b100;
         order[2] = 3'b001;
         order[3] = 3'b010;
         order[4] = 3'b100;
         for (int g = 0; g < 5; g++) begin
            tick();
            checkOutput("cont_grant", 64'(grant), 64'(order[g]));
            if (g < 4) begin
               tick();
               checkOutput("cont_idle", 64'(grant), 64'h0);
            end
         end
      end
      @(negedge clk);
      req_wr = '0;
      #1;
      checkOutput("cont_end_grant", 64'(grant), 64'h0);

      // read burst of 8 on requester 1 with 3 busy cycles; pointer is 0
      @(negedge clk);
      ddr.ddr_busy = 1'b1;
      applyStimulus(1, 1'b1, 1'b0, 29'h0ABCDE, 8'd8, 64'h0);
      #1;
      checkOutput("rd_arb_grant", 64'(grant), 64'h0);
      for (int c = 0; c < 3; c++) begin
         tick();
         checkOutput("rd_busy_grant", 64'(grant), 64'h2);
         checkOutput("rd_busy_rd", 64'(ddr.ddr_rd), 64'h1);
         checkOutput("rd_busy_wait_n", 64'(req_wait_n), 64'h0);
         checkOutput("rd_addr", 64'(ddr.ddr_addr), 64'h0ABCDE);
         checkOutput("rd_burst", 64'(ddr.ddr_burst), 64'd8);
      end
      @(negedge clk);
      ddr.ddr_busy = 1'b0;
      #1;
      checkOutput("rd_accept_wait_n", 64'(req_wait_n), 64'h2);
      checkOutput("rd_accept_rd", 64'(ddr.ddr_rd), 64'h1);
      @(negedge clk);
      req_rd[1] = 1'b0;
      #1;
      checkOutput("rd_data_rd_low", 64'(ddr.ddr_rd), 64'h0);
      for (int b = 0; b < 8; b++) begin
         @(negedge clk);
         ddr.ddr_valid = 1'b1;
         ddr.ddr_dout = 64'hD000_0000_0000_0000 + 64'(b);
         #1;
         checkOutput("rd_valid", 64'(req_valid), 64'h2);
         checkOutput("rd_dout", req_dout, 64'hD000_0000_0000_0000 + 64'(b));
      end
      @(negedge clk);
      ddr.ddr_valid = 1'b0;
      #1;
      checkOutput("rd_done_grant", 64'(grant), 64'h0);
      checkOutput("rd_done_err", 64'(err), 64'h0);

      // wrap: pointer is 2, only requester 0 pending, burst 0 acts as one beat
      @(negedge clk);
      applyStimulus(0, 1'b0, 1'b1, 29'h77, 8'd0, 64'h77);
      #1;
      checkOutput("wrap_arb_grant", 64'(grant), 64'h0);
      tick();
      checkOutput("wrap_grant", 64'(grant), 64'h1);
      checkOutput("wrap_we", 64'(ddr.ddr_we), 64'h1);
      checkOutput("wrap_burst", 64'(ddr.ddr_burst), 64'h0);
      @(negedge clk);
      req_wr[0] = 1'b0;
      #1;
      checkOutput("wrap_done_grant", 64'(grant), 64'h0);
      checkOutput("wrap_done_we", 64'(ddr.ddr_we), 64'h0);

      // simultaneous rd+wr on requester 2: write first, read granted next
      @(negedge clk);
      applyStimulus(2, 1'b1, 1'b1, 29'h222, 8'd1, 64'h2222);
      #1;
      tick();
      checkOutput("rw_wr_grant", 64'(grant), 64'h4);
      checkOutput("rw_wr_we", 64'(ddr.ddr_we), 64'h1);
      checkOutput("rw_wr_rd", 64'(ddr.ddr_rd), 64'h0);
      @(negedge clk);
      req_wr[2] = 1'b0;
      #1;
      checkOutput("rw_gap_grant", 64'(grant), 64'h0);
      tick();
      checkOutput("rw_rd_grant", 64'(grant), 64'h4);
      checkOutput("rw_rd_rd", 64'(ddr.ddr_rd), 64'h1);
      @(negedge clk);
      req_rd[2] = 1'b0;
      ddr.ddr_valid = 1'b1;
      ddr.ddr_dout = 64'h5555;
      #1;
      checkOutput("rw_rd_valid", 64'(req_valid), 64'h4);
      @(negedge clk);
      ddr.ddr_valid = 1'b0;
      #1;
      checkOutput("rw_done_grant", 64'(grant), 64'h0);

      // reset in the middle of a read burst; later beats are strays
      @(negedge clk);
      applyStimulus(0, 1'b1, 1'b0, 29'h333, 8'd8, 64'h0);
      #1;
      tick();
      checkOutput("rst_rd_cmd", 64'(ddr.ddr_rd), 64'h1);
      @(negedge clk);
      req_rd[0] = 1'b0;
      for (int b = 0; b < 3; b++) begin
         @(negedge clk);
         ddr.ddr_valid = 1'b1;
         #1;
         checkOutput("rst_pre_valid", 64'(req_valid), 64'h1);
      end
      @(negedge clk);
      ddr.ddr_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      checkOutput("rst_abort_grant", 64'(grant), 64'h0);
      checkOutput("rst_abort_err", 64'(err), 64'h0);
      for (int b = 0; b < 5; b++) begin
         @(negedge clk);
         ddr.ddr_valid = 1'b1;
         #1;
         checkOutput("stray_valid", 64'(req_valid), 64'h0);
      end
      @(negedge clk);
      ddr.ddr_valid = 1'b0;
      #1;
      checkOutput("stray_err", 64'(err), 64'h1);
      tick();
      checkOutput("err_sticky", 64'(err), 64'h1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      checkOutput("err_cleared", 64'(err), 64'h0);

      $display("%0d/%0d checks passed", passCount, totalCount);
      $finish;
   end
endmodule
